// File: rtl/matrix_bank_responder.sv
// matrix_bank_responder: three size x size cell banks behind a request
// interface; one cell fetched per cycle, reads answered with a ready pulse.
module matrix_bank_responder #(
    parameter int size          = 4,
    parameter int cell_width    = 32,
    parameter int address_width = 4,
    parameter int width         = cell_width * size
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic [address_width-1:0] in_reg_address,
    input  logic [1:0]               in_type,
    input  logic [1:0]               in_matrix,
    input  logic                     in_read_en,
    input  logic                     in_write_en,
    input  logic [width-1:0]         in_cell_data,
    output logic [width-1:0]         out_data,
    output logic                     out_data_ready,
    output logic                     out_busy,
    output logic                     out_error
);
    localparam int cells = size * size;
    localparam int idx_w = $clog2(3 * cells);
    localparam int cnt_w = $clog2(size + 1);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
    state_t state, state_next;

    logic [cell_width-1:0]    mem [3*cells];
    logic [address_width-1:0] lat_addr;
    logic [1:0]               lat_type;
    logic [1:0]               lat_matrix;
    logic                     lat_bad;
    logic [cnt_w-1:0]         idx;
    logic [cnt_w-1:0]         count;
    logic [width-1:0]         asm_buf;
    logic [width-1:0]         asm_next;
    logic                     pend_valid;
    logic [idx_w-1:0]         pend_idx;
    logic [cell_width-1:0]    pend_data;
    logic                     wr_ok;
    logic                     rd_bad;
    logic                     last;
    logic [idx_w-1:0]         wr_idx;
    logic [idx_w-1:0]         f_row;
    logic [idx_w-1:0]         f_col;
    logic [idx_w-1:0]         f_off;
    logic [idx_w-1:0]         f_lin;
    logic [cell_width-1:0]    f_cell;
    logic                     unused_hi;

    assign unused_hi = ^in_cell_data[width-1:cell_width];

    assign wr_ok = in_write_en && in_type == 2'b00 && in_matrix != 2'b11
                   && int'(in_reg_address) < cells;
    assign rd_bad = in_matrix == 2'b11 || in_type == 2'b11
                    || (in_type == 2'b00 && int'(in_reg_address) >= cells);
    assign wr_idx = idx_w'(in_matrix) * idx_w'(cells)
                    + idx_w'(in_reg_address);
    assign last = (idx == count - cnt_w'(1));

    // Address of the cell fetched this cycle and the vector it completes
    always_comb begin
        f_row = idx_w'(int'(lat_addr) / size);
        f_col = idx_w'(int'(lat_addr) % size);
        unique case (1'b1)
            lat_type == 2'b01: f_off = f_row * idx_w'(size) + idx_w'(idx);
            lat_type == 2'b10: f_off = idx_w'(idx) * idx_w'(size) + f_col;
            default:           f_off = idx_w'(lat_addr);
        endcase
        f_lin = idx_w'(lat_matrix) * idx_w'(cells) + f_off;
        f_cell = '0;
        if (!lat_bad && int'(f_lin) < 3 * cells)
            f_cell = mem[f_lin];
        asm_next = asm_buf;
        asm_next[int'(idx)*cell_width +: cell_width] = f_cell;
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_read_en) state_next = FETCH;
            FETCH:   if (last) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_busy = (state != IDLE);
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            lat_addr       <= '0;
            lat_type       <= '0;
            lat_matrix     <= '0;
            lat_bad        <= 1'b0;
            idx            <= '0;
            count          <= '0;
            asm_buf        <= '0;
            out_data       <= '0;
            out_data_ready <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_read_en) begin
                    lat_addr   <= in_reg_address;
                    lat_type   <= in_type;
                    lat_matrix <= in_matrix;
                    lat_bad    <= rd_bad;
                    asm_buf    <= '0;
                    idx        <= '0;
                    count      <= (in_type == 2'b00 || rd_bad)
                                  ? cnt_w'(1) : cnt_w'(size);
                end
                FETCH: begin
                    asm_buf <= asm_next;
                    idx     <= idx + cnt_w'(1);
                    if (last) begin
                        out_data       <= asm_next;
                        out_data_ready <= 1'b1;
                    end
                end
                RESP:    out_data_ready <= 1'b0;
                default: ;
            endcase
        end
    end

    // Writes seen while busy wait in a single slot until the next IDLE edge
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_data  <= '0;
        end else if (state == IDLE) begin
            pend_valid <= 1'b0;
        end else if (wr_ok && !pend_valid) begin
            pend_valid <= 1'b1;
            pend_idx   <= wr_idx;
            pend_data  <= in_cell_data[cell_width-1:0];
        end
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            for (int i = 0; i < 3 * cells; i++) mem[i] <= '0;
        end else if (state == IDLE) begin
            if (pend_valid) mem[pend_idx] <= pend_data;
            if (wr_ok)      mem[wr_idx]   <= in_cell_data[cell_width-1:0];
        end
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset)
            out_error <= 1'b0;
        else if ((in_write_en && !wr_ok)
                 || (wr_ok && state != IDLE && pend_valid)
                 || (state == IDLE && in_read_en && rd_bad))
            out_error <= 1'b1;
    end
endmodule

// File: tb/tb_matrix_bank_responder.sv
// Directed bench for matrix_bank_responder: cell/row/column reads,
// pending writes, error flag and mid-read reset.
module tb_matrix_bank_responder;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         in_reset;
    logic [3:0]   in_reg_address;
    logic [1:0]   in_type;
    logic [1:0]   in_matrix;
    logic         in_read_en;
    logic         in_write_en;
    logic [W-1:0] in_cell_data;
    logic [W-1:0] out_data;
    logic         out_data_ready;
    logic         out_busy;
    logic         out_error;

    int n_vec = 0;
    int n_bad = 0;
    bit busy_seen;
    bit rdy_seen;

    matrix_bank_responder dut (
        .in_clk        (clk),
        .in_reset      (in_reset),
        .in_reg_address(in_reg_address),
        .in_type       (in_type),
        .in_matrix     (in_matrix),
        .in_read_en    (in_read_en),
        .in_write_en   (in_write_en),
        .in_cell_data  (in_cell_data),
        .out_data      (out_data),
        .out_data_ready(out_data_ready),
        .out_busy      (out_busy),
        .out_error     (out_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [31:0] s0, s1, s2, s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic wr(input logic [1:0] m, input logic [1:0] t,
                      input logic [3:0] a, input logic [31:0] d);
        in_matrix      = m;
        in_type        = t;
        in_reg_address = a;
        in_cell_data   = {96'b0, d};
        in_write_en    = 1'b1;
        @(negedge clk);
        in_write_en = 1'b0;
        if (out_busy) busy_seen = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [1:0] m,
                      input logic [1:0] t, input logic [3:0] a, input int n,
                      input logic [W-1:0] exp, input bit inject);
        int cyc;
        bit seen;
        in_matrix      = m;
        in_type        = t;
        in_reg_address = a;
        in_read_en     = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (inject && cyc == 1) begin
                in_matrix = 2'd2; in_type = 2'd0; in_reg_address = 4'd7;
                in_cell_data = {96'b0, 32'hAA}; in_write_en = 1'b1;
            end
            if (inject && cyc == 2) in_cell_data = {96'b0, 32'hBB};
            if (inject && cyc == 3) in_write_en = 1'b0;
            if (out_data_ready) seen = 1'b1;
        end
        in_read_en  = 1'b0;
        in_write_en = 1'b0;
        check({tag, "_lat"}, W'(cyc), W'(n + 1));
        check({tag, "_data"}, out_data, exp);
        @(negedge clk);
        check({tag, "_pulse"}, W'(out_data_ready), W'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_reset = 1'b1; in_reg_address = '0; in_type = '0; in_matrix = '0;
        in_read_en = 1'b0; in_write_en = 1'b0; in_cell_data = '0;
        busy_seen = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", out_data, W'(0));
        check("rst_ready", W'(out_data_ready), W'(0));
        check("rst_busy", W'(out_busy), W'(0));
        check("rst_error", W'(out_error), W'(0));
        in_reset = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                wr(2'd0, 2'd0, 4'(r*4 + c), 32'(r*4 + c + 1));
                wr(2'd1, 2'd0, 4'(r*4 + c), 32'(16 * (r*4 + c)));
            end
        check("busy_writes", W'(busy_seen), W'(0));

        rd("row_a8", 2'd0, 2'd1, 4'd8, 4, pack(9, 10, 11, 12), 1'b0);
        rd("col_b3", 2'd1, 2'd2, 4'd3, 4, pack(48, 112, 176, 240), 1'b0);
        wr(2'd2, 2'd0, 4'd5, 32'h1234);
        rd("cell_c5", 2'd2, 2'd0, 4'd5, 1, pack(32'h1234, 0, 0, 0), 1'b0);
        repeat (3) @(negedge clk);
        check("hold", out_data, pack(32'h1234, 0, 0, 0));
        check("err_clean", W'(out_error), W'(0));

        rd("row_c1_pend", 2'd2, 2'd1, 4'd4, 4, pack(0, 32'h1234, 0, 0), 1'b1);
        check("err_drop", W'(out_error), W'(1));
        rd("cell_c7", 2'd2, 2'd0, 4'd7, 1, pack(32'hAA, 0, 0, 0), 1'b0);

        in_matrix = 2'd0; in_type = 2'd1; in_reg_address = 4'd0;
        in_read_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("busy_fetch", W'(out_busy), W'(1));
        in_reset = 1'b1;
        in_read_en = 1'b0;
        #1;
        check("rstf_busy", W'(out_busy), W'(0));
        check("rstf_error", W'(out_error), W'(0));
        check("rstf_data", out_data, W'(0));
        rdy_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_data_ready) rdy_seen = 1'b1;
        end
        in_reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_data_ready) rdy_seen = 1'b1;
        end
        check("rstf_no_ready", W'(rdy_seen), W'(0));
        rd("row_a2_zero", 2'd0, 2'd1, 4'd8, 4, W'(0), 1'b0);
        check("err_after_rst", W'(out_error), W'(0));

        wr(2'd0, 2'd0, 4'd1, 32'h99);
        rd("cell_a1", 2'd0, 2'd0, 4'd1, 1, pack(32'h99, 0, 0, 0), 1'b0);
        rd("bad_mat", 2'd3, 2'd0, 4'd1, 1, W'(0), 1'b0);
        check("err_bad_rd", W'(out_error), W'(1));
        repeat (5) @(negedge clk);
        check("err_sticky", W'(out_error), W'(1));

        in_reset = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        @(negedge clk);
        check("err_cleared", W'(out_error), W'(0));
        wr(2'd0, 2'd0, 4'd2, 32'h77);
        check("err_good_wr", W'(out_error), W'(0));
        wr(2'd0, 2'd1, 4'd2, 32'h55);
        check("err_row_wr", W'(out_error), W'(1));
        rd("cell_a2", 2'd0, 2'd0, 4'd2, 1, pack(32'h77, 0, 0, 0), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
